audio_dac_i2s_tx: RTL and testbench

AUDIO_DAC_I2S_TX -- requirements
Module: audio_dac_i2s_tx

---
 rtl/audio_pkg.sv | 10 +
 rtl/sample_fifo.sv | 43 ++++
 rtl/audio_dac_i2s_tx.sv | 97 +++++++++
 tb/tb_audio_dac_i2s_tx.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// Shared constants and types for the I2S audio DAC transmit path.
package audio_pkg;
  localparam int DATA_W_DEF = 16;
  localparam int UNDERRUN_W = 8;

  typedef struct packed {
    logic [DATA_W_DEF-1:0] left;
    logic [DATA_W_DEF-1:0] right;
  } frame_t;
endpackage

// File: rtl/sample_fifo.sv
// Stereo frame FIFO; full_nxt is the full state after this cycle's push/pop.
module sample_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             CLK,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic             full_nxt
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr, rd_ptr, cnt, cnt_nxt;
  logic             do_push, do_pop;

  assign cnt      = wr_ptr - rd_ptr;
  assign full     = (cnt == (AW+1)'(DEPTH));
  assign empty    = (cnt == '0);
  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;
  assign cnt_nxt  = cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
  assign full_nxt = (cnt_nxt == (AW+1)'(DEPTH));
  assign dout     = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge CLK) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr[AW-1:0]] <= din;
        wr_ptr <= wr_ptr + (AW+1)'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end
endmodule

// File: rtl/audio_dac_i2s_tx.sv
// I2S DAC transmitter: buffers stereo frames and serializes them against
// codec-driven BCLK/LRCK, which are synchronized into the CLK domain.
module audio_dac_i2s_tx import audio_pkg::*; #(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  CLK,
  input  logic                  rst,
  input  logic [DATA_W-1:0]     s_left,
  input  logic [DATA_W-1:0]     s_right,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic                  AUD_BCLK,
  input  logic                  AUD_DACLRCK,
  output logic                  AUD_DACDAT,
  output logic                  underrun,
  output logic [UNDERRUN_W-1:0] underrun_cnt
);
  localparam int CW = $clog2(DATA_W + 2);
  localparam logic [CW-1:0] CNT_DONE = CW'(DATA_W + 1);

  // [0],[1] synchronizer stages, [2] history for edge detection
  logic [2:0] bclk_sy, lrck_sy;
  logic       bclk_fall, lrck_fall, lrck_rise;

  logic [2*DATA_W-1:0] fifo_dout;
  logic                fifo_full, fifo_empty, fifo_full_nxt, fifo_push;

  logic [DATA_W-1:0] sr, right_hold;
  logic [CW-1:0]     bit_cnt;
  logic              aligned;

  assign bclk_fall = bclk_sy[2] & ~bclk_sy[1];
  assign lrck_fall = lrck_sy[2] & ~lrck_sy[1];
  assign lrck_rise = ~lrck_sy[2] & lrck_sy[1];
  assign fifo_push = s_valid & s_ready & ~fifo_full;

  sample_fifo #(.WIDTH(2*DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .CLK      (CLK),
    .rst      (rst),
    .push     (fifo_push),
    .din      ({s_left, s_right}),
    .pop      (lrck_fall),
    .dout     (fifo_dout),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .full_nxt (fifo_full_nxt)
  );

  always_ff @(posedge CLK) begin
    if (!rst) begin
      bclk_sy      <= '0;
      lrck_sy      <= '0;
      s_ready      <= 1'b0;
      sr           <= '0;
      right_hold   <= '0;
      bit_cnt      <= '0;
      aligned      <= 1'b0;
      AUD_DACDAT   <= 1'b0;
      underrun     <= 1'b0;
      underrun_cnt <= '0;
    end else begin
      bclk_sy <= {bclk_sy[1:0], AUD_BCLK};
      lrck_sy <= {lrck_sy[1:0], AUD_DACLRCK};
      s_ready <= ~fifo_full_nxt;

      if (lrck_fall) begin
        aligned <= 1'b1;
        if (fifo_empty) begin
          sr         <= '0;
          right_hold <= '0;
          underrun   <= 1'b1;
          if (underrun_cnt != '1) underrun_cnt <= underrun_cnt + 1'b1;
        end else begin
          sr         <= fifo_dout[2*DATA_W-1:DATA_W];
          right_hold <= fifo_dout[DATA_W-1:0];
        end
      end else if (lrck_rise && aligned) begin
        sr <= right_hold;
      end

      // Slot after each LRCK edge is the I2S one-bit delay, always 0
      if (lrck_fall || lrck_rise) begin
        bit_cnt <= bclk_fall ? CW'(1) : '0;
        if (bclk_fall) AUD_DACDAT <= 1'b0;
      end else if (bclk_fall) begin
        if (bit_cnt != CNT_DONE) bit_cnt <= bit_cnt + CW'(1);
        if (!aligned || bit_cnt == '0 || bit_cnt == CNT_DONE) begin
          AUD_DACDAT <= 1'b0;
        end else begin
          AUD_DACDAT <= sr[DATA_W-1];
          sr         <= {sr[DATA_W-2:0], 1'b0};
        end
      end
    end
  end
endmodule

// File: tb/tb_audio_dac_i2s_tx.sv
// Directed bench: codec clock model driven in slots, one task per scenario.
module tb_audio_dac_i2s_tx;
  import audio_pkg::*;

  logic        CLK = 1'b0, rst = 1'b0, s_valid = 1'b0;
  logic        AUD_BCLK = 1'b1, AUD_DACLRCK = 1'b1;
  logic [15:0] s_left = '0, s_right = '0;
  logic        s_ready, AUD_DACDAT, underrun;
  logic [7:0]  underrun_cnt;

  int n_vec = 0;
  int n_err = 0;
  int half  = 8;  // CLK cycles per BCLK half period

  always #10 CLK = ~CLK;

  audio_dac_i2s_tx #(.DATA_W(16), .FIFO_DEPTH(4)) dut (
    .CLK          (CLK),
    .rst          (rst),
    .s_left       (s_left),
    .s_right      (s_right),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .AUD_BCLK     (AUD_BCLK),
    .AUD_DACLRCK  (AUD_DACLRCK),
    .AUD_DACDAT   (AUD_DACDAT),
    .underrun     (underrun),
    .underrun_cnt (underrun_cnt)
  );

  // One BCLK period; LRCK changes with the falling edge. d is the bit driven for that fall.
  task automatic slot(input logic lr, output logic d);
    @(negedge CLK);
    AUD_BCLK = 1'b0;
    AUD_DACLRCK = lr;
    repeat (half) @(negedge CLK);
    AUD_BCLK = 1'b1;
    repeat (half - 1) @(negedge CLK);
    d = AUD_DACDAT;
  endtask

  // n slots of one channel half; slot i lands in w[31-i]
  task automatic chan(input logic lr, input int n, output logic [31:0] w);
    logic d;
    w = '0;
    for (int i = 0; i < n; i++) begin
      slot(lr, d);
      w[31-i] = d;
    end
  endtask

  task automatic push(input logic [15:0] l, input logic [15:0] r, output logic acc);
    @(negedge CLK);
    s_left = l;
    s_right = r;
    s_valid = 1'b1;
    acc = s_ready;
  endtask

  task automatic idle();
    @(negedge CLK);
    s_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge CLK);
    rst = 1'b0;
    s_valid = 1'b0;
    repeat (4) @(negedge CLK);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge CLK);
    n_vec++; if (s_ready !== 1'b0) begin n_err++; $display("FAIL reset_s_ready: got %b want 0", s_ready); end
    n_vec++; if (AUD_DACDAT !== 1'b0) begin n_err++; $display("FAIL reset_dacdat: got %b want 0", AUD_DACDAT); end
    n_vec++; if (underrun !== 1'b0) begin n_err++; $display("FAIL reset_underrun: got %b want 0", underrun); end
    n_vec++; if (underrun_cnt !== 8'd0) begin n_err++; $display("FAIL reset_cnt: got %0d want 0", underrun_cnt); end
    rst = 1'b1;
    @(negedge CLK);
    n_vec++; if (s_ready !== 1'b1) begin n_err++; $display("FAIL release_s_ready: got %b want 1", s_ready); end
  endtask

  // Reset was released with LRCK high: right half is skipped, then the frame plays.
  task automatic test_basic_word();
    logic acc;
    logic [31:0] w;
    push(16'hA5C3, 16'h0F0F, acc);
    idle();
    n_vec++; if (acc !== 1'b1) begin n_err++; $display("FAIL basic_accept: got %b want 1", acc); end
    chan(1'b1, 32, w);
    n_vec++; if (w !== 32'h0) begin n_err++; $display("FAIL prealign_right: got %h want %h", w, 32'h0); end
    chan(1'b0, 32, w);
    n_vec++; if (w !== {1'b0, 16'hA5C3, 15'h0}) begin n_err++; $display("FAIL basic_left: got %h want %h", w, {1'b0, 16'hA5C3, 15'h0}); end
    chan(1'b1, 32, w);
    n_vec++; if (w !== {1'b0, 16'h0F0F, 15'h0}) begin n_err++; $display("FAIL basic_right: got %h want %h", w, {1'b0, 16'h0F0F, 15'h0}); end
    n_vec++; if (underrun !== 1'b0) begin n_err++; $display("FAIL basic_no_underrun: got %b want 0", underrun); end
  endtask

  task automatic test_underrun();
    logic [31:0] w;
    logic [31:0] ored;
    do_reset();
    ored = '0;
    for (int k = 0; k < 3; k++) begin
      chan(1'b0, 32, w); ored |= w;
      chan(1'b1, 32, w); ored |= w;
    end
    n_vec++; if (ored !== 32'h0) begin n_err++; $display("FAIL underrun_data: got %h want %h", ored, 32'h0); end
    n_vec++; if (underrun !== 1'b1) begin n_err++; $display("FAIL underrun_flag: got %b want 1", underrun); end
    n_vec++; if (underrun_cnt !== 8'd3) begin n_err++; $display("FAIL underrun_cnt3: got %0d want 3", underrun_cnt); end
    half = 4;
    for (int k = 0; k < 247; k++) begin
      chan(1'b0, 2, w);
      chan(1'b1, 2, w);
    end
    n_vec++; if (underrun_cnt !== 8'd250) begin n_err++; $display("FAIL underrun_cnt250: got %0d want 250", underrun_cnt); end
    for (int k = 0; k < 50; k++) begin
      chan(1'b0, 2, w);
      chan(1'b1, 2, w);
    end
    n_vec++; if (underrun_cnt !== 8'd255) begin n_err++; $display("FAIL underrun_sat: got %0d want 255", underrun_cnt); end
    half = 8;
  endtask

  task automatic test_back_to_back();
    frame_t      fr [5];
    logic [4:0]  acc;
    logic        a;
    logic [31:0] w;
    fr = '{'{16'h8001, 16'h0180}, '{16'h4002, 16'h0240}, '{16'h2004, 16'h0420},
           '{16'h1008, 16'h0810}, '{16'hF00F, 16'h7FFE}};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      push(fr[i].left, fr[i].right, a);
      acc[i] = a;
    end
    idle();
    n_vec++; if (acc !== 5'b01111) begin n_err++; $display("FAIL b2b_accepts: got %b want %b", acc, 5'b01111); end
    n_vec++; if (s_ready !== 1'b0) begin n_err++; $display("FAIL b2b_full: got %b want 0", s_ready); end
    chan(1'b0, 32, w);
    n_vec++; if (w !== {1'b0, fr[0].left, 15'h0}) begin n_err++; $display("FAIL b2b_left0: got %h want %h", w, {1'b0, fr[0].left, 15'h0}); end
    n_vec++; if (s_ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready_after_pop: got %b want 1", s_ready); end
    push(fr[4].left, fr[4].right, a);
    idle();
    n_vec++; if (a !== 1'b1) begin n_err++; $display("FAIL b2b_fifth_accept: got %b want 1", a); end
    chan(1'b1, 32, w);
    n_vec++; if (w !== {1'b0, fr[0].right, 15'h0}) begin n_err++; $display("FAIL b2b_right0: got %h want %h", w, {1'b0, fr[0].right, 15'h0}); end
    for (int i = 1; i < 5; i++) begin
      chan(1'b0, 32, w);
      n_vec++; if (w !== {1'b0, fr[i].left, 15'h0}) begin n_err++; $display("FAIL b2b_left%0d: got %h want %h", i, w, {1'b0, fr[i].left, 15'h0}); end
      chan(1'b1, 32, w);
      n_vec++; if (w !== {1'b0, fr[i].right, 15'h0}) begin n_err++; $display("FAIL b2b_right%0d: got %h want %h", i, w, {1'b0, fr[i].right, 15'h0}); end
    end
    n_vec++; if (underrun !== 1'b0) begin n_err++; $display("FAIL b2b_no_underrun: got %b want 0", underrun); end
  endtask

  task automatic test_reset_mid_word();
    logic        a;
    logic [31:0] w;
    do_reset();
    chan(1'b1, 32, w);
    chan(1'b0, 32, w);
    chan(1'b1, 32, w);
    n_vec++; if (underrun_cnt !== 8'd1) begin n_err++; $display("FAIL mid_pre_cnt: got %0d want 1", underrun_cnt); end
    push(16'hFFFF, 16'hFFFF, a);
    push(16'h1234, 16'h5678, a);
    idle();
    chan(1'b0, 9, w);
    n_vec++; if (w[31:23] !== 9'b0_1111_1111) begin n_err++; $display("FAIL mid_partial: got %b want %b", w[31:23], 9'b0_1111_1111); end
    @(negedge CLK);
    rst = 1'b0;
    @(negedge CLK);
    n_vec++; if (AUD_DACDAT !== 1'b0) begin n_err++; $display("FAIL mid_dacdat: got %b want 0", AUD_DACDAT); end
    n_vec++; if (underrun !== 1'b0) begin n_err++; $display("FAIL mid_underrun: got %b want 0", underrun); end
    n_vec++; if (underrun_cnt !== 8'd0) begin n_err++; $display("FAIL mid_cnt: got %0d want 0", underrun_cnt); end
    @(negedge CLK);
    rst = 1'b1;
    chan(1'b0, 23, w);
    n_vec++; if (w !== 32'h0) begin n_err++; $display("FAIL mid_rest_left: got %h want %h", w, 32'h0); end
    chan(1'b1, 32, w);
    chan(1'b0, 32, w);
    n_vec++; if (w !== 32'h0) begin n_err++; $display("FAIL mid_next_left: got %h want %h", w, 32'h0); end
    n_vec++; if (underrun_cnt !== 8'd1) begin n_err++; $display("FAIL mid_fifo_emptied: got %0d want 1", underrun_cnt); end
    chan(1'b1, 32, w);
  endtask

  // Push lands in the exact CLK cycle the DUT acts on the LRCK fall.
  task automatic test_push_on_fall();
    logic        a, d;
    logic [31:0] w;
    do_reset();
    chan(1'b1, 32, w);
    @(negedge CLK);
    AUD_BCLK = 1'b0;
    AUD_DACLRCK = 1'b0;
    repeat (2) @(negedge CLK);
    s_left = 16'h3C5A;
    s_right = 16'hC3A5;
    s_valid = 1'b1;
    a = s_ready;
    @(negedge CLK);
    s_valid = 1'b0;
    repeat (half - 3) @(negedge CLK);
    AUD_BCLK = 1'b1;
    repeat (half - 1) @(negedge CLK);
    d = AUD_DACDAT;
    n_vec++; if (a !== 1'b1) begin n_err++; $display("FAIL pof_accept: got %b want 1", a); end
    n_vec++; if (d !== 1'b0) begin n_err++; $display("FAIL pof_slot0: got %b want 0", d); end
    chan(1'b0, 31, w);
    n_vec++; if (w !== 32'h0) begin n_err++; $display("FAIL pof_left_zero: got %h want %h", w, 32'h0); end
    n_vec++; if (underrun_cnt !== 8'd1) begin n_err++; $display("FAIL pof_cnt: got %0d want 1", underrun_cnt); end
    chan(1'b1, 32, w);
    n_vec++; if (w !== 32'h0) begin n_err++; $display("FAIL pof_right_zero: got %h want %h", w, 32'h0); end
    chan(1'b0, 32, w);
    n_vec++; if (w !== {1'b0, 16'h3C5A, 15'h0}) begin n_err++; $display("FAIL pof_left: got %h want %h", w, {1'b0, 16'h3C5A, 15'h0}); end
    chan(1'b1, 32, w);
    n_vec++; if (w !== {1'b0, 16'hC3A5, 15'h0}) begin n_err++; $display("FAIL pof_right: got %h want %h", w, {1'b0, 16'hC3A5, 15'h0}); end
  endtask

  initial begin
    #(4ms);
    n_err++;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic_word();
    test_underrun();
    test_back_to_back();
    test_reset_mid_word();
    test_push_on_fall();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
